pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
// Central stall/flush sequencer for the 5-stage RV64 pipeline. Consumes the branch-resolve result
// (taken flag + target) from the ID/EX branch unit, the load-use hazard inputs and the data-memory
// busy flag, then drives PC/pipeline-register write enables, bubble/flush controls and the PC redirect.
// Holds a multi-cycle flush FSM and saturating event counters for performance debug.
// PARAMETERS
// FLUSH_CYCLES  2   total cycles ifid_flush/idex_flush held per taken branch, incl. resolve cycle (>=1)
// CNT_W         32  width of each saturating event counter
// PORTS
// clk            in   1      rising-edge clock
// reset          in   1      asynchronous, active-high reset
// branch_valid   in   1      branch instruction resolving this cycle
// branch_taken   in   1      branch-unit taken result; qualified by branch_valid
// branch_target  in   64     redirect address for a taken branch
// idex_memread   in   1      instruction in ID/EX is a load
// idex_rd        in   5      destination register of ID/EX instruction
// ifid_rs1       in   5      rs1 of IF/ID instruction
// ifid_rs2       in   5      rs2 of IF/ID instruction
// mem_busy       in   1      data memory not ready; whole pipeline must freeze
// pc_write       out  1      PC register write enable
// ifid_write     out  1      IF/ID register write enable
// pipe_write     out  1      ID/EX, EX/MEM, MEM/WB write enable
// ifid_flush     out  1      load NOP into IF/ID
// idex_flush     out  1      load bubble (control zeroed) into ID/EX
// pc_src         out  1      1: PC <= pc_redirect; 0: PC <= PC+4
// pc_redirect    out  64     redirect address, valid when pc_src=1, else 0
// flushing       out  1      FSM in FLUSH state
// branch_count   out  CNT_W  branches resolved (accepted branch_valid)
// taken_count    out  CNT_W  taken branches accepted
// stall_count    out  CNT_W  load-use stall cycles
// BEHAVIOUR
// - States: RUN, FLUSH. Counter fcnt (clog2(FLUSH_CYCLES)+1 bits). All control outputs are combinational
//   from state + inputs; only state, fcnt, event counters are registered.
// - Default outputs (RUN, no event): pc_write=ifid_write=pipe_write=1, flushes=0, pc_src=0, pc_redirect=0.
// - Priority per cycle: mem_busy > FSM FLUSH > taken branch > load-use hazard.
// - mem_busy=1 (any state): pc_write=ifid_write=pipe_write=0, flushes=0, pc_src=0; state, fcnt and
//   counters hold; branch_taken/hazard ignored (re-evaluated once mem_busy drops).
// - RUN, branch_valid&branch_taken: pc_src=1, pc_redirect=branch_target, ifid_flush=idex_flush=1,
//   write enables 1. If FLUSH_CYCLES>1: next state FLUSH, fcnt<=FLUSH_CYCLES-2; else stay RUN.
// - FLUSH: ifid_flush=idex_flush=1, pc_src=0, write enables 1; branch_valid/taken and hazard ignored
//   (wrong-path). fcnt==0 -> RUN next cycle, else fcnt decrements.
// - RUN, no taken branch, hazard = idex_memread & (idex_rd!=0) & (idex_rd==ifid_rs1 | idex_rd==ifid_rs2):
//   pc_write=ifid_write=0, idex_flush=1, pipe_write=1. No state change; one stall per hazard cycle.
// - Branch_taken without branch_valid is ignored. Not-taken branch: no flush, normal flow.
// - Counters (only in non-frozen RUN cycles): branch_count+=branch_valid; taken_count+=branch_valid&
//   branch_taken; stall_count+=hazard applied. Each saturates at 2^CNT_W-1, never wraps.
// - Reset (async, any time incl. mid-FLUSH): state=RUN, fcnt=0, all counters 0; outputs immediately take
//   RUN defaults for current inputs.
// TESTING
// - Taken beq, target 0x0000_0000_0000_0040, FLUSH_CYCLES=2 -> cycle0 pc_src=1, redirect=0x40, both flushes;
//   cycle1 flushes only, flushing=1; cycle2 defaults; taken_count=1, branch_count=1.
// - ld x5 in ID/EX, add x6,x5,x7 in IF/ID -> one cycle pc_write=ifid_write=0, idex_flush=1; stall_count=1.
//   Same with idex_rd=0 -> no stall.
// - Taken branch + simultaneous load-use -> branch wins: pc_src=1, pc_write=1, stall_count unchanged.
// - mem_busy high 3 cycles during FLUSH (fcnt=0) -> all write enables 0, flushes 0, state held;
//   after release one more flush cycle then RUN.
// - Second taken branch during FLUSH -> ignored, taken_count unchanged; reset asserted mid-FLUSH ->
//   immediate RUN, counters 0.
// - CNT_W=4, 20 taken branches spaced apart -> taken_count saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch redirect with a
// multi-cycle flush window, whole-pipe freeze on data-memory busy, and saturating event counters.
//
// state | meaning
// RUN   | normal flow; taken branches and load-use hazards are evaluated
// FLUSH | wrong-path window after a taken branch; IF/ID and ID/EX are flushed
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             branch_valid,
   input  logic             branch_taken,
   input  logic [63:0]      branch_target,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rd,
   input  logic [4:0]       ifid_rs1,
   input  logic [4:0]       ifid_rs2,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             pipe_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             pc_src,
   output logic [63:0]      pc_redirect,
   output logic             flushing,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] taken_count,
   output logic [CNT_W-1:0] stall_count
);

   localparam int FCNT_W = $clog2(FLUSH_CYCLES) + 1;
   localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);
   localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic br_taken;
   logic hazard;
   logic run_active;
   logic stall_applied;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
      return (en && (cnt != '1)) ? cnt + 1'b1 : cnt;
   endfunction

   assign br_taken   = branch_valid & branch_taken;
   assign hazard     = idex_memread & (idex_rd != 5'd0) &
                       ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));
   // Only an unfrozen RUN cycle may act on branch or hazard inputs.
   assign run_active    = !mem_busy && (state_q == RUN);
   assign stall_applied = run_active && !br_taken && hazard;

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      pipe_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      pc_src      = 1'b0;
      pc_redirect = 64'd0;
      if (mem_busy) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_write = 1'b0;
      end else if (state_q == FLUSH) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (br_taken) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         pc_src      = 1'b1;
         pc_redirect = branch_target;
      end else if (hazard) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (!mem_busy) begin
         if (state_q == FLUSH) begin
            if (fcnt_q == '0) begin
               state_d = RUN;
            end else begin
               fcnt_d = fcnt_q - 1'b1;
            end
         end else if (br_taken && MULTI_FLUSH) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_INIT;
         end
      end
   end

   always_comb begin
      branch_cnt_d = sat_inc(branch_cnt_q, run_active && branch_valid);
      taken_cnt_d  = sat_inc(taken_cnt_q, run_active && br_taken);
      stall_cnt_d  = sat_inc(stall_cnt_q, stall_applied);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RUN;
         fcnt_q       <= '0;
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         fcnt_q       <= fcnt_d;
         branch_cnt_q <= branch_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign flushing     = (state_q == FLUSH);
   assign branch_count = branch_cnt_q;
   assign taken_count  = taken_cnt_q;
   assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; a driver queues expected responses and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 4;

   // {pc_write, ifid_write, pipe_write, ifid_flush, idex_flush, pc_src}
   localparam logic [5:0] NORM  = 6'b111_000;
   localparam logic [5:0] BR    = 6'b111_111;
   localparam logic [5:0] FL    = 6'b111_110;
   localparam logic [5:0] STALL = 6'b001_010;
   localparam logic [5:0] FRZ   = 6'b000_000;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             branch_valid = 1'b0;
   logic             branch_taken = 1'b0;
   logic [63:0]      branch_target = 64'd0;
   logic             idex_memread = 1'b0;
   logic [4:0]       idex_rd = 5'd0;
   logic [4:0]       ifid_rs1 = 5'd0;
   logic [4:0]       ifid_rs2 = 5'd0;
   logic             mem_busy = 1'b0;
   logic             pc_write, ifid_write, pipe_write, ifid_flush, idex_flush, pc_src;
   logic [63:0]      pc_redirect;
   logic             flushing;
   logic [CNT_W-1:0] branch_count, taken_count, stall_count;

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .branch_valid(branch_valid), .branch_taken(branch_taken), .branch_target(branch_target),
      .idex_memread(idex_memread), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .mem_busy(mem_busy),
      .pc_write(pc_write), .ifid_write(ifid_write), .pipe_write(pipe_write),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pc_src(pc_src),
      .pc_redirect(pc_redirect), .flushing(flushing),
      .branch_count(branch_count), .taken_count(taken_count), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               id;
      logic [5:0]       ctl;
      logic [63:0]      redir;
      logic             fl;
      logic [CNT_W-1:0] bc;
      logic [CNT_W-1:0] tc;
      logic [CNT_W-1:0] sc;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   vid = 0;

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         logic [5:0] ctl;
         e   = sb_q.pop_front();
         ctl = {pc_write, ifid_write, pipe_write, ifid_flush, idex_flush, pc_src};
         n_vec++;
         if (ctl !== e.ctl) begin
            n_err++;
            $display("FAIL v%0d ctl: got %b want %b", e.id, ctl, e.ctl);
         end
         if (pc_redirect !== e.redir) begin
            n_err++;
            $display("FAIL v%0d pc_redirect: got %h want %h", e.id, pc_redirect, e.redir);
         end
         if (flushing !== e.fl) begin
            n_err++;
            $display("FAIL v%0d flushing: got %b want %b", e.id, flushing, e.fl);
         end
         if (branch_count !== e.bc) begin
            n_err++;
            $display("FAIL v%0d branch_count: got %0d want %0d", e.id, branch_count, e.bc);
         end
         if (taken_count !== e.tc) begin
            n_err++;
            $display("FAIL v%0d taken_count: got %0d want %0d", e.id, taken_count, e.tc);
         end
         if (stall_count !== e.sc) begin
            n_err++;
            $display("FAIL v%0d stall_count: got %0d want %0d", e.id, stall_count, e.sc);
         end
      end
   end

   // One vector per cycle: drive after the edge, expectation observed at the following negedge.
   task automatic v(input logic rst_v, input logic bv, input logic bt, input logic [63:0] tgt,
                    input logic mr, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic busy, input logic [5:0] ctl, input logic [63:0] rdr, input logic fl,
                    input int bc, input int tc, input int sc);
      exp_t e;
      reset         = rst_v;
      branch_valid  = bv;
      branch_taken  = bt;
      branch_target = tgt;
      idex_memread  = mr;
      idex_rd       = rd;
      ifid_rs1      = rs1;
      ifid_rs2      = rs2;
      mem_busy      = busy;
      vid++;
      e.id    = vid;
      e.ctl   = ctl;
      e.redir = rdr;
      e.fl    = fl;
      e.bc    = CNT_W'(bc);
      e.tc    = CNT_W'(tc);
      e.sc    = CNT_W'(sc);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic int sat15(input int x);
      return (x > 15) ? 15 : x;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1);
   end

   initial begin
      @(posedge clk);
      #1;
      //  rst bv bt tgt        mr rd  rs1 rs2 busy | ctl   redir      fl bc tc sc
      v(1, 0, 0, 64'h0,     0, 0,  0,  0,  0,  NORM,  64'h0,     0, 0, 0, 0);
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  0,  NORM,  64'h0,     0, 0, 0, 0);
      v(0, 1, 1, 64'h40,    0, 0,  0,  0,  0,  BR,    64'h40,    0, 0, 0, 0);
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  0,  FL,    64'h0,     1, 1, 1, 0);
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  0,  NORM,  64'h0,     0, 1, 1, 0);
      v(0, 0, 0, 64'h0,     1, 5,  5,  7,  0,  STALL, 64'h0,     0, 1, 1, 0);
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  0,  NORM,  64'h0,     0, 1, 1, 1);
      v(0, 0, 0, 64'h0,     1, 0,  0,  7,  0,  NORM,  64'h0,     0, 1, 1, 1);
      v(0, 0, 0, 64'h0,     1, 9,  1,  9,  0,  STALL, 64'h0,     0, 1, 1, 1);
      v(0, 0, 0, 64'h0,     0, 9,  9,  9,  0,  NORM,  64'h0,     0, 1, 1, 2);
      v(0, 1, 0, 64'h44,    0, 0,  0,  0,  0,  NORM,  64'h0,     0, 1, 1, 2);
      v(0, 0, 1, 64'h80,    0, 0,  0,  0,  0,  NORM,  64'h0,     0, 2, 1, 2);
      // taken branch beats a simultaneous load-use hazard
      v(0, 1, 1, 64'h100,   1, 5,  5,  0,  0,  BR,    64'h100,   0, 2, 1, 2);
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  1,  FRZ,   64'h0,     1, 3, 2, 2);
      v(0, 1, 1, 64'h180,   1, 3,  3,  3,  1,  FRZ,   64'h0,     1, 3, 2, 2);
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  1,  FRZ,   64'h0,     1, 3, 2, 2);
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  0,  FL,    64'h0,     1, 3, 2, 2);
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  0,  NORM,  64'h0,     0, 3, 2, 2);
      // freeze in RUN ignores branch and hazard
      v(0, 1, 1, 64'h1c0,   1, 4,  4,  4,  1,  FRZ,   64'h0,     0, 3, 2, 2);
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  0,  NORM,  64'h0,     0, 3, 2, 2);
      v(0, 1, 1, 64'h200,   0, 0,  0,  0,  0,  BR,    64'h200,   0, 3, 2, 2);
      v(0, 1, 1, 64'h300,   1, 6,  6,  6,  0,  FL,    64'h0,     1, 4, 3, 2);
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  0,  NORM,  64'h0,     0, 4, 3, 2);
      v(0, 1, 1, 64'h400,   0, 0,  0,  0,  0,  BR,    64'h400,   0, 4, 3, 2);
      // asynchronous reset mid-FLUSH takes effect before the next edge
      v(1, 0, 0, 64'h0,     0, 0,  0,  0,  0,  NORM,  64'h0,     0, 0, 0, 0);
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  0,  NORM,  64'h0,     0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         v(0, 1, 1, 64'h1000 + 64'(i * 16), 0, 0, 0, 0, 0, BR, 64'h1000 + 64'(i * 16), 0,
           sat15(i), sat15(i), 0);
         v(0, 0, 0, 64'h0, 0, 0, 0, 0, 0, FL, 64'h0, 1, sat15(i + 1), sat15(i + 1), 0);
      end
      v(0, 0, 0, 64'h0,     0, 0,  0,  0,  0,  NORM,  64'h0,     0, 15, 15, 0);
      for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
      if (sb_q.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
